// File: rtl/nes_loader_pkg.sv
// Shared types and widths for the ROM-loader to SDRAM write path.
// Latency: n/a. Backpressure: n/a.
// Holds the loader bus widths and the bridge FSM state encoding.
package nes_loader_pkg;

  localparam int LOADER_ADDR_W = 22;
  localparam int LOADER_DATA_W = 8;

  typedef enum logic {
    ST_IDLE,
    ST_WRITE
  } state_t;

endpackage

// File: rtl/loader_fifo.sv
// Synchronous register-array FIFO with level count and synchronous clear.
// Latency: pushed entry visible at the head on the next clk.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module loader_fifo #(
  parameter int WIDTH      = 30,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wr_dat,
  output logic [WIDTH-1:0]      rd_dat,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  wr_en;
  logic                  rd_en;

  assign full   = (level == FULL_LVL);
  assign empty  = (level == '0);
  assign rd_dat = mem[rd_ptr];

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign rd_en = pop && !empty && !clr;
  assign wr_en = push && (!full || rd_en) && !clr;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/loader_mem_bridge.sv
// Queues GameLoader byte writes and replays them into SDRAM on NES bus slots.
// Latency: push to mem_write is 1-4 clk (next slot); one byte per slot sustained.
// Backpressure: none upstream; pushes into a full FIFO are dropped and flag overflow.
module loader_mem_bridge
  import nes_loader_pkg::*;
#(
  parameter int ADDR_W     = LOADER_ADDR_W,
  parameter int DATA_W     = LOADER_DATA_W,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  slot,
  input  logic                  flush,
  input  logic                  in_write,
  input  logic [ADDR_W-1:0]     in_addr,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  mem_write,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  idle
);

  localparam int W = ADDR_W + DATA_W;

  state_t         state;
  state_t         state_nxt;
  logic           fifo_full;
  logic           fifo_empty;
  logic [W-1:0]   head;
  logic           pop;
  logic           load;
  logic           mem_write_nxt;

  loader_fifo #(
    .WIDTH      (W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .clr    (flush),
    .push   (in_write),
    .pop    (pop),
    .wr_dat ({in_addr, in_data}),
    .rd_dat (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (level)
  );

  assign idle = fifo_empty && (state == ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush)      state_nxt = ST_IDLE;
    else if (slot)  state_nxt = fifo_empty ? ST_IDLE : ST_WRITE;
  end

  // Every slot with data pops, both from IDLE and as a back-to-back write.
  always_comb begin
    pop           = slot && !fifo_empty && !flush;
    load          = pop;
    mem_write_nxt = (state_nxt == ST_WRITE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      mem_write <= mem_write_nxt;
      if (load) {mem_addr, mem_data} <= head;
      if (flush)                                   overflow <= 1'b0;
      else if (in_write && fifo_full && !pop)      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_loader_mem_bridge.sv
// Directed bench for loader_mem_bridge: slot timing, burst ordering, overflow, flush, async reset.
module tb_loader_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        slot;
  logic        flush;
  logic        in_write;
  logic [21:0] in_addr;
  logic [7:0]  in_data;
  logic        mem_write;
  logic [21:0] mem_addr;
  logic [7:0]  mem_data;
  logic [3:0]  level;
  logic        overflow;
  logic        idle;

  int tests = 0;
  int fails = 0;
  int phase = 0;
  bit slot_en = 1'b1;
  bit last_slot = 1'b0;

  always #5 clk = ~clk;

  loader_mem_bridge dut (
    .clk       (clk),
    .reset     (reset),
    .slot      (slot),
    .flush     (flush),
    .in_write  (in_write),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .level     (level),
    .overflow  (overflow),
    .idle      (idle)
  );

  // Inputs change at negedge; outputs are observed at the following negedge.
  task automatic tick();
    slot = slot_en && (phase == 3);
    last_slot = slot;
    @(posedge clk);
    phase = (phase + 1) % 4;
    @(negedge clk);
  endtask

  task automatic align(input int p);
    for (int i = 0; i < 4 && phase != p; i++) tick();
  endtask

  task automatic push(input logic [21:0] a, input logic [7:0] d);
    in_write = 1'b1; in_addr = a; in_data = d;
    tick();
    in_write = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic drain(input logic [21:0] base_a, input logic [7:0] base_d, input int n);
    int got = 0;
    for (int c = 0; c < 4*n + 12; c++) begin
      tick();
      if (last_slot && mem_write) begin
        tests++;
        if (mem_addr !== base_a + 22'(got) || mem_data !== base_d + 8'(got)) begin
          fails++;
          $display("FAIL drain_entry%0d: got %h/%h expected %h/%h", got, mem_addr, mem_data,
                   base_a + 22'(got), base_d + 8'(got));
        end
        got++;
      end
      if (got == n && idle) break;
    end
    tests++;
    if (got !== n || idle !== 1'b1) begin
      fails++;
      $display("FAIL drain_count: got %0d writes idle=%b expected %0d idle=1", got, idle, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if ({mem_write, mem_addr, mem_data, level, overflow, idle} !== {1'b0, 22'h0, 8'h0, 4'd0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_values: got mw=%b a=%h d=%h lvl=%0d ovf=%b idle=%b expected 0/0/0/0/0/1",
               mem_write, mem_addr, mem_data, level, overflow, idle);
    end
    reset = 1'b0;
    phase = 0;
  endtask

  task automatic test_single();
    align(1);
    push(22'h000010, 8'hA5);
    tests++;
    if (level !== 4'd1 || mem_write !== 1'b0) begin
      fails++; $display("FAIL single_queued: got lvl=%0d mw=%b expected 1/0", level, mem_write);
    end
    tick();
    tests++;
    if (mem_write !== 1'b0) begin
      fails++; $display("FAIL single_early: got mw=%b expected 0", mem_write);
    end
    tick();
    tests++;
    if (mem_write !== 1'b1 || mem_addr !== 22'h000010 || mem_data !== 8'hA5 || idle !== 1'b0 || level !== 4'd0) begin
      fails++;
      $display("FAIL single_write: got mw=%b %h/%h idle=%b lvl=%0d expected 1 000010/a5 0 0",
               mem_write, mem_addr, mem_data, idle, level);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (mem_write !== 1'b1) begin
        fails++; $display("FAIL single_hold%0d: got mw=%b expected 1", i, mem_write);
      end
    end
    tick();
    tests++;
    if (mem_write !== 1'b0 || idle !== 1'b1) begin
      fails++; $display("FAIL single_end: got mw=%b idle=%b expected 0/1", mem_write, idle);
    end
  endtask

  task automatic test_burst();
    int hi = 0;
    align(0);
    for (int i = 0; i < 3; i++) push(22'h000100 + 22'(i), 8'h10 + 8'(i));
    tests++;
    if (level !== 4'd3) begin
      fails++; $display("FAIL burst_level: got %0d expected 3", level);
    end
    for (int k = 0; k < 16; k++) begin
      tick();
      if (mem_write) hi++;
      if (k == 0 || k == 4 || k == 8) begin
        tests++;
        if (mem_write !== 1'b1 || mem_addr !== 22'h000100 + 22'(k/4) || mem_data !== 8'h10 + 8'(k/4)) begin
          fails++;
          $display("FAIL burst_entry%0d: got mw=%b %h/%h expected 1 %h/%h", k/4, mem_write,
                   mem_addr, mem_data, 22'h000100 + 22'(k/4), 8'h10 + 8'(k/4));
        end
      end
    end
    tests++;
    if (hi !== 12) begin
      fails++; $display("FAIL burst_high_cycles: got %0d expected 12", hi);
    end
  endtask

  task automatic test_overflow();
    slot_en = 1'b0;
    for (int i = 0; i < 8; i++) push(22'(i), 8'h80 + 8'(i));
    tests++;
    if (level !== 4'd8 || overflow !== 1'b0) begin
      fails++; $display("FAIL ovf_full: got lvl=%0d ovf=%b expected 8/0", level, overflow);
    end
    push(22'd8, 8'h88);
    tests++;
    if (level !== 4'd8 || overflow !== 1'b1) begin
      fails++; $display("FAIL ovf_drop: got lvl=%0d ovf=%b expected 8/1", level, overflow);
    end
    slot_en = 1'b1;
    drain(22'd0, 8'h80, 8);
    tests++;
    if (overflow !== 1'b1) begin
      fails++; $display("FAIL ovf_sticky: got %b expected 1", overflow);
    end
  endtask

  task automatic test_full_pop();
    do_flush();
    tests++;
    if (overflow !== 1'b0 || level !== 4'd0) begin
      fails++; $display("FAIL fullpop_flush: got ovf=%b lvl=%0d expected 0/0", overflow, level);
    end
    slot_en = 1'b0;
    for (int i = 0; i < 8; i++) push(22'h000020 + 22'(i), 8'h40 + 8'(i));
    slot_en = 1'b1;
    align(3);
    push(22'h000028, 8'h48);
    tests++;
    if (level !== 4'd8 || overflow !== 1'b0 || mem_write !== 1'b1 || mem_addr !== 22'h000020) begin
      fails++;
      $display("FAIL fullpop_same_cycle: got lvl=%0d ovf=%b mw=%b a=%h expected 8/0/1/000020",
               level, overflow, mem_write, mem_addr);
    end
    drain(22'h000021, 8'h41, 8);
  endtask

  task automatic test_flush();
    int hi = 0;
    slot_en = 1'b0;
    for (int i = 0; i < 9; i++) push(22'h000030 + 22'(i), 8'h60 + 8'(i));
    slot_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      align(3);
      tick();
    end
    tests++;
    if (level !== 4'd5 || mem_write !== 1'b1 || mem_addr !== 22'h000032 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL flush_setup: got lvl=%0d mw=%b a=%h ovf=%b expected 5/1/000032/1",
               level, mem_write, mem_addr, overflow);
    end
    tick();
    do_flush();
    tests++;
    if (mem_write !== 1'b0 || level !== 4'd0 || overflow !== 1'b0 || idle !== 1'b1) begin
      fails++;
      $display("FAIL flush_clear: got mw=%b lvl=%0d ovf=%b idle=%b expected 0/0/0/1",
               mem_write, level, overflow, idle);
    end
    for (int k = 0; k < 12; k++) begin
      tick();
      if (mem_write) hi++;
    end
    tests++;
    if (hi !== 0) begin
      fails++; $display("FAIL flush_no_writes: got %0d high cycles expected 0", hi);
    end
  endtask

  task automatic test_async_reset();
    int hi = 0;
    align(0);
    push(22'h3FFFFF, 8'hFF);
    push(22'h000555, 8'h55);
    align(3);
    tick();
    tests++;
    if (mem_write !== 1'b1 || mem_addr !== 22'h3FFFFF || level !== 4'd1) begin
      fails++; $display("FAIL areset_setup: got mw=%b a=%h lvl=%0d expected 1/3fffff/1", mem_write, mem_addr, level);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({mem_write, mem_addr, mem_data, level, overflow, idle} !== {1'b0, 22'h0, 8'h0, 4'd0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL areset_values: got mw=%b a=%h d=%h lvl=%0d ovf=%b idle=%b expected 0/0/0/0/0/1",
               mem_write, mem_addr, mem_data, level, overflow, idle);
    end
    @(negedge clk);
    reset = 1'b0;
    phase = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (mem_write) hi++;
    end
    tests++;
    if (hi !== 0 || idle !== 1'b1) begin
      fails++; $display("FAIL areset_discard: got %0d high cycles idle=%b expected 0/1", hi, idle);
    end
  endtask

  initial begin
    slot = 1'b0; flush = 1'b0; in_write = 1'b0; in_addr = '0; in_data = '0;
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_full_pop();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/loader_mem_bridge.md
# loader_mem_bridge

Buffers byte writes produced by the ROM loader (GameLoader) and replays them into the SDRAM controller's shared write port. Each write is aligned to the NES bus slot so that it never collides with CPU/PPU traffic. It sits between GameLoader's `mem_addr`/`mem_data`/`mem_write` outputs and the SDRAM `addr`/`din`/`we` inputs, in the `clk_nes` domain. It replaces the single-entry trigger register with a FIFO, so that loader bursts faster than one byte per NES cycle are not lost.

## Interface
Parameters:
- `ADDR_W`, default 22: SDRAM byte address width.
- `DATA_W`, default 8: data width.
- `DEPTH_LOG2`, default 3: FIFO depth is 2^DEPTH_LOG2 entries (8).

Ports:
- `clk` in 1: `clk_nes`, 21 MHz. This is the only clock.
- `reset` in 1: asynchronous, active-high.
- `slot` in 1: one-cycle strobe, high when `nes_ce == 3`. It arrives every 4th `clk`.
- `flush` in 1: synchronous clear. It is driven high while `downloading` is low.
- `in_write` in 1: loader write strobe, one cycle per byte.
- `in_addr` in ADDR_W: loader address, valid with `in_write`.
- `in_data` in DATA_W: loader data, valid with `in_write`.
- `mem_write` out 1: SDRAM write request. It is held for one full NES cycle.
- `mem_addr` out ADDR_W: address presented to SDRAM.
- `mem_data` out DATA_W: data presented to SDRAM.
- `level` out DEPTH_LOG2+1: current FIFO occupancy, from 0 to 2^DEPTH_LOG2.
- `overflow` out 1: sticky flag, set when a byte was dropped.
- `idle` out 1: FIFO is empty and the FSM is in IDLE.

## Operation
- Push: when `in_write` is high and the FIFO is not full, store {`in_addr`, `in_data`} at the write pointer.
- Full push: when `in_write` is high and the FIFO is full, drop the byte and set `overflow`. `level` is unchanged.
- FSM states are IDLE and WRITE.
- IDLE, on `slot` with FIFO not empty:
  - pop the head into the `mem_addr`/`mem_data` registers;
  - set `mem_write` to 1;
  - go to WRITE.
- WRITE holds its outputs until the next `slot`.
- WRITE, on `slot` with FIFO not empty: pop the next entry and stay in WRITE. This is a back-to-back write, and `mem_write` stays at 1.
- WRITE, on `slot` with FIFO empty: clear `mem_write` and go to IDLE.
- Simultaneous push and pop:
  - both take effect and `level` is unchanged;
  - this is legal even when the FIFO is full, because the pop frees the entry in the same cycle;
  - this is also legal when the FIFO is empty: a push on a `slot` cycle in IDLE is not popped until the next `slot`. There is no bypass.
- `flush` has priority over push and pop. It:
  - resets the pointers;
  - sets `level` to 0;
  - clears `overflow`;
  - sets `mem_write` to 0;
  - sends the FSM to IDLE.
- `mem_addr` and `mem_data` keep their last values in IDLE. They are don't-care there, but they must not toggle.
- Pointer arithmetic:
  - the pointers are DEPTH_LOG2 bits wide and wrap modulo 2^DEPTH_LOG2;
  - `level` is DEPTH_LOG2+1 bits wide;
  - full is `level == 2^DEPTH_LOG2`;
  - empty is `level == 0`.

## Timing
- Reset values (async assert, sync release):
  - `mem_write` = 0;
  - `mem_addr` = 0;
  - `mem_data` = 0;
  - `level` = 0;
  - `overflow` = 0;
  - `idle` = 1;
  - state = IDLE.
- Reset mid-WRITE drops `mem_write` immediately. The FIFO contents are discarded.
- Latency from push to `mem_write` is 1 to 4 clk when the FIFO is empty and the FSM is IDLE. It equals the distance to the next `slot`, with a minimum of 1 clk, because the FIFO is registered.
- `mem_write`, `mem_addr` and `mem_data` change only on the clk edge following a `slot` cycle, or on `flush`/reset.
- Sustained throughput is one byte per 4 clk. Inputs faster than this accumulate in the FIFO.
- `overflow` sets on the clk edge after the dropped push.
- `idle` is combinational from registered state.

## Structure
- Shared package `nes_loader_pkg` holds:
  - `LOADER_ADDR_W = 22`;
  - `LOADER_DATA_W = 8`;
  - the FSM state enum {ST_IDLE, ST_WRITE}.
- Sub-module `loader_fifo` is a synchronous FIFO. It has:
  - `push`/`pop`/`clr` inputs;
  - `full`/`empty`/`level` outputs;
  - a register-array storage of width ADDR_W+DATA_W.
- The top holds the FSM, the output registers and the `overflow` flag.

## Test plan
- Single write, in_write at addr 0x000010 with data 0xA5 two clk before `slot`: `mem_write` rises after `slot` carrying 0x000010/0xA5. It stays high 4 clk and falls after the next `slot`. `idle` returns to 1.
- Burst of 3 writes on consecutive clk: `mem_write` stays high for 12 clk covering the 3 entries in order. `level` peaks at 3.
- 9 pushes before any `slot` (depth 8): the 9th byte is dropped and `overflow` = 1. Then 8 writes are emitted in order, addresses 0 to 7.
- Push on the same cycle as a pop while full: the entry is accepted, `level` stays 8 and `overflow` stays 0.
- `flush` asserted in the middle of WRITE with `level` = 5: the next clk has `mem_write` = 0, `level` = 0 and `overflow` = 0, with no further writes.
- Async `reset` pulse between clk edges during WRITE: `mem_write` goes to 0 without waiting for a clk edge. All outputs are at their reset values.
